// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: control-field bit indices,
// forwarding select encodings, sequencer state codes and the forwarding priority helper.
// No logic or state of its own; it has no flow control.
package hazard_sequencer_pkg;

   // Bit positions inside the decoded control bundles
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int M_BRANCH    = 2;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;

   // EX operand select encodings
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } seq_state_t;

   // The younger producer (EX/MEM) holds the newest value, so it wins over MEM/WB
   function automatic logic [1:0] fwd_pick(input logic exmem_hit, input logic memwb_hit);
      if (exmem_hit) return FWD_EXMEM;
      if (memwb_hit) return FWD_MEMWB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_sequencer_fwd_select.sv
// Purpose: EX operand forwarding selects from the ID/EX sources against the EX/MEM and MEM/WB producers.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only compares shadow fields.
module hazard_sequencer_fwd_select
   import hazard_sequencer_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] idex_rs,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] exmem_dest,
   input  logic             exmem_regwrite,
   input  logic [REG_W-1:0] memwb_dest,
   input  logic             memwb_regwrite,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   logic exmem_live;
   logic memwb_live;

   // Register 0 is hardwired, so a producer targeting it never forwards
   assign exmem_live = exmem_regwrite && (exmem_dest != '0);
   assign memwb_live = memwb_regwrite && (memwb_dest != '0);

   assign fwd_a = fwd_pick(exmem_live && (exmem_dest == idex_rs),
                           memwb_live && (memwb_dest == idex_rs));
   assign fwd_b = fwd_pick(exmem_live && (exmem_dest == idex_rt),
                           memwb_live && (memwb_dest == idex_rt));

endmodule

// File: rtl/hazard_sequencer.sv
// Purpose: hazard detection, stall/flush sequencing, EX forwarding and host halt/drain for the 5-stage core.
// Latency: control outputs are combinational from state, shadows and ID inputs (zero cycles).
// Backpressure: a stall holds PC and IF/ID for one cycle and bubbles ID/EX; DRAIN/HALTED freeze fetch.
// Option macro HAZARD_FORWARDING_EN: forwarding with load-use-only stalls; otherwise stall on any RAW match.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int REG_W     = 5,
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic [1:0]       id_wb,
   input  logic [2:0]       id_m,
   input  logic             ex_branch_taken,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYC - 1);

   seq_state_t         state;
   logic [DCNT_W-1:0]  drain_cnt;
   logic               halt_pend;

   // Hazard shadows of the datapath pipeline registers
   logic [REG_W-1:0]   idex_dest, idex_rs, idex_rt;
   logic               idex_regwrite, idex_memread;
   logic [REG_W-1:0]   exmem_dest, memwb_dest;
   logic               exmem_regwrite, memwb_regwrite;

   logic               idex_hit;
   logic               hazard;
   logic               stall_now;
   logic [1:0]         fwd_a_raw, fwd_b_raw;

   // ID sources against the ID/EX producer; rt only matters when the instruction reads it
   assign idex_hit = idex_regwrite && (idex_dest != '0) &&
                     ((id_rs == idex_dest) || (id_uses_rt && (id_rt == idex_dest)));

`ifdef HAZARD_FORWARDING_EN
   // Everything but a load result can be forwarded, so only load-use stalls
   assign hazard = idex_memread && idex_hit;

   hazard_sequencer_fwd_select #(.REG_W(REG_W)) u_fwd_select (
      .idex_rs        (idex_rs),
      .idex_rt        (idex_rt),
      .exmem_dest     (exmem_dest),
      .exmem_regwrite (exmem_regwrite),
      .memwb_dest     (memwb_dest),
      .memwb_regwrite (memwb_regwrite),
      .fwd_a          (fwd_a_raw),
      .fwd_b          (fwd_b_raw)
   );
`else
   logic exmem_hit;
   logic unused_nofwd;

   // Without forwarding the consumer waits until its producer reaches MEM/WB
   assign exmem_hit = exmem_regwrite && (exmem_dest != '0) &&
                      ((id_rs == exmem_dest) || (id_uses_rt && (id_rt == exmem_dest)));
   assign hazard    = idex_hit || exmem_hit;
   assign fwd_a_raw = FWD_REG;
   assign fwd_b_raw = FWD_REG;
   assign unused_nofwd = ^{idex_rs, idex_rt, idex_memread, memwb_dest, memwb_regwrite};
`endif

   logic unused_ctl;
   assign unused_ctl = ^{id_wb[WB_MEMTOREG], id_m[M_BRANCH], id_m[M_MEMWRITE]};

   // Pipeline control: reset and frozen states first, then taken branch over stall
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      stall_now  = 1'b0;
      if (reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (hazard) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
                  stall_now  = 1'b1;
               end
            end
            ST_DRAIN: begin
               pc_write   = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end
            default: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               halted     = (state == ST_HALTED);
            end
         endcase
      end
   end

   assign fwd_a = reset ? FWD_REG : fwd_a_raw;
   assign fwd_b = reset ? FWD_REG : fwd_b_raw;

   // Run/drain/halt sequencing; a halt blocked by a taken branch drains on the next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         halt_pend <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (halt_pend || (halt_req && !ex_branch_taken)) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_INIT;
                  halt_pend <= 1'b0;
               end else if (halt_req) begin
                  halt_pend <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) state <= ST_HALTED;
               else                 drain_cnt <= drain_cnt - 1'b1;
            end
            ST_HALTED: begin
               if (resume) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Shadow advance; a flushed ID/EX slot becomes an all-zero bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         idex_dest      <= '0;
         idex_rs        <= '0;
         idex_rt        <= '0;
         idex_regwrite  <= 1'b0;
         idex_memread   <= 1'b0;
         exmem_dest     <= '0;
         exmem_regwrite <= 1'b0;
         memwb_dest     <= '0;
         memwb_regwrite <= 1'b0;
      end else begin
         idex_dest      <= idex_flush ? '0   : id_dest;
         idex_rs        <= idex_flush ? '0   : id_rs;
         idex_rt        <= idex_flush ? '0   : id_rt;
         idex_regwrite  <= idex_flush ? 1'b0 : id_wb[WB_REGWRITE];
         idex_memread   <= idex_flush ? 1'b0 : id_m[M_MEMREAD];
         exmem_dest     <= idex_dest;
         exmem_regwrite <= idex_regwrite;
         memwb_dest     <= exmem_dest;
         memwb_regwrite <= exmem_regwrite;
      end
   end

   // Saturating count of stall cycles actually taken
   always_ff @(posedge clk) begin
      if (reset)                                  stall_cycles <= '0;
      else if (stall_now && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule
